encoder_counter: RTL and testbench



---
 rtl/encoder_counter.sv | 41 ++++
 tb/tb_encoder_counter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_counter.sv
// encoder_counter: counts filtered edges of an asynchronous pulse input.
// A is synchronized and glitch-filtered, then selected edges advance Count while En is high.
module encoder_counter #(
  parameter int WIDTH      = 8,
  parameter int FILTER_LEN = 4,
  parameter int EDGE_MODE  = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             A,
  input  logic             En,
  output logic [WIDTH-1:0] Count
);
  localparam logic [3:0] FL = 4'(FILTER_LEN);
  logic s1, s2, f, f_d, rise, fall, hit, acc;
  logic [3:0] r, r_inc;
  always_comb begin
    r_inc = r + 4'd1;
    acc   = (s2 != f) && (r_inc == FL);
    rise  = f & ~f_d;
    fall  = ~f & f_d;
    hit   = EDGE_MODE == 1 ? fall : EDGE_MODE == 2 ? rise | fall : rise;
  end
  // r only runs while s2 disagrees with the accepted level, so any shorter excursion restarts it
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      f     <= 1'b0;
      f_d   <= 1'b0;
      r     <= 4'd0;
      Count <= '0;
    end else begin
      s1  <= A;
      s2  <= s1;
      f_d <= f;
      r   <= (s2 == f || acc) ? 4'd0 : r_inc;
      if (acc) f <= s2;
      if (hit && En) Count <= Count + WIDTH'(1);
    end
endmodule

// File: tb/tb_encoder_counter.sv
// tb_encoder_counter: scoreboard bench for all three edge modes driven from a run-length model of A.
module tb_encoder_counter;
  localparam int FL = 4;
  typedef struct {int m; int t; logic [7:0] v;} exp_t;
  logic CLK = 1'b0, RST = 1'b1, A = 1'b0, En = 1'b0;
  logic [7:0] cnt [3];
  exp_t sb[$];
  int tests = 0, fails = 0, t_now = 0;
  logic [7:0] mc [3];
  logic [7:0] prev [3];
  int run_len = 0;
  logic run_lvl = 1'b0, fm = 1'b0;
  int pend_t[$];
  logic pend_f[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    encoder_counter #(.WIDTH(8), .FILTER_LEN(FL), .EDGE_MODE(g)) dut (
      .CLK(CLK), .RST(RST), .A(A), .En(En), .Count(cnt[g]));
  end

  always #5 CLK = ~CLK;

  // An accepted level change is a run of FL equal samples differing from the current level;
  // its count lands 3 edges after the run's FL-th sample, gated by En at that edge.
  task automatic step(input logic a, input logic e);
    logic lv;
    A = a;
    En = e;
    if (pend_t.size() > 0 && pend_t[0] == t_now) begin
      lv = pend_f.pop_front();
      void'(pend_t.pop_front());
      if (e)
        for (int m = 0; m < 3; m++)
          if ((m == 0 && lv) || (m == 1 && !lv) || m == 2) begin
            mc[m]++;
            sb.push_back('{m, t_now, mc[m]});
          end
    end
    if (a == run_lvl) run_len++;
    else begin
      run_lvl = a;
      run_len = 1;
    end
    if (run_lvl != fm && run_len == FL) begin
      fm = run_lvl;
      pend_t.push_back(t_now + 3);
      pend_f.push_back(fm);
    end
    @(posedge CLK);
    t_now++;
    #2;
  endtask

  task automatic hold(input logic a, input logic e, input int n);
    repeat (n) step(a, e);
  endtask

  task automatic pulses(input int n, input int hi, input int lo, input logic e);
    repeat (n) begin
      hold(1'b1, e, hi);
      hold(1'b0, e, lo);
    end
  endtask

  task automatic chk(input string nm, input int m, input logic [7:0] expv);
    tests++;
    if (cnt[m] !== expv) begin
      fails++;
      $display("FAIL %s inst=%0d count=%0d expected=%0d", nm, m, cnt[m], expv);
    end
  endtask

  task automatic chk_all(input string nm);
    for (int m = 0; m < 3; m++) chk(nm, m, mc[m]);
  endtask

  task automatic do_reset(input int n);
    @(negedge CLK);
    #1;
    RST = 1'b1;
    #1;
    for (int m = 0; m < 3; m++) chk("async_reset", m, 8'd0);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL missed_change pending=%0d expected=0", sb.size());
      sb.delete();
    end
    for (int m = 0; m < 3; m++) begin
      mc[m] = 8'd0;
      prev[m] = 8'd0;
    end
    fm = 1'b0;
    run_lvl = 1'b0;
    run_len = 0;
    pend_t.delete();
    pend_f.delete();
    repeat (n) @(posedge CLK);
    t_now += n;
    #2;
    RST = 1'b0;
  endtask

  always @(negedge CLK)
    if (!RST)
      for (int m = 0; m < 3; m++)
        if (cnt[m] !== prev[m]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < sb.size(); i++) if (idx < 0 && sb[i].m == m) idx = i;
          tests++;
          if (idx < 0) begin
            fails++;
            $display("FAIL unexpected_change inst=%0d count=%0d expected=%0d edge=%0d", m, cnt[m], prev[m], t_now - 1);
          end else begin
            if (sb[idx].v !== cnt[m] || sb[idx].t != t_now - 1) begin
              fails++;
              $display("FAIL change inst=%0d count=%0d@%0d expected=%0d@%0d", m, cnt[m], t_now - 1, sb[idx].v, sb[idx].t);
            end
            sb.delete(idx);
          end
          prev[m] = cnt[m];
        end

  initial begin
    logic lvl;
    for (int m = 0; m < 3; m++) begin
      mc[m] = 8'd0;
      prev[m] = 8'd0;
    end
    #1;
    for (int m = 0; m < 3; m++) chk("reset_state", m, 8'd0);
    repeat (10) @(posedge CLK);
    #2;
    RST = 1'b0;
    lvl = 1'b0;
    repeat (9) begin
      lvl = ~lvl;
      hold(lvl, 1'b0, 586);
    end
    for (int m = 0; m < 3; m++) chk("disabled", m, 8'd0);

    do_reset(10);
    hold(1'b0, 1'b1, 586);
    pulses(4, 586, 586, 1'b1);
    chk("basic", 0, 8'd4);
    chk_all("basic_model");

    do_reset(2);
    hold(1'b0, 1'b1, 10);
    for (int w = 1; w <= 4; w++) begin
      hold(1'b1, 1'b1, w);
      hold(1'b0, 1'b1, 10);
    end
    chk("glitch_rise", 0, 8'd1);
    chk("glitch_both", 2, 8'd2);

    do_reset(2);
    hold(1'b0, 1'b1, 4);
    pulses(128, 4, 4, 1'b1);
    hold(1'b0, 1'b1, 8);
    chk("wrap_both", 2, 8'd0);
    chk("wrap_half", 0, 8'd128);
    pulses(127, 4, 4, 1'b1);
    hold(1'b0, 1'b1, 8);
    chk("wrap_255", 0, 8'd255);
    chk("wrap_255_fall", 1, 8'd255);
    pulses(1, 4, 4, 1'b1);
    hold(1'b0, 1'b1, 8);
    chk("wrap_0", 0, 8'd0);
    chk("wrap_0_fall", 1, 8'd0);
    chk("wrap_0_both", 2, 8'd0);

    do_reset(2);
    hold(1'b1, 1'b0, 20);
    hold(1'b1, 1'b1, 20);
    chk("en_raise", 0, 8'd0);
    hold(1'b0, 1'b0, 8);
    pulses(3, 4, 4, 1'b0);
    hold(1'b0, 1'b0, 8);
    hold(1'b0, 1'b1, 20);
    chk("en_drop", 0, 8'd0);
    chk_all("en_drop_model");
    pulses(1, 4, 4, 1'b1);
    hold(1'b0, 1'b1, 8);
    chk("en_resume", 0, 8'd1);

    do_reset(2);
    hold(1'b0, 1'b1, 4);
    pulses(5, 4, 4, 1'b1);
    hold(1'b0, 1'b1, 8);
    chk("pre_reset", 0, 8'd5);
    hold(1'b1, 1'b1, 2);
    do_reset(3);
    hold(1'b1, 1'b1, 10);
    chk("reset_high", 0, 8'd1);
    chk_all("reset_high_model");
    hold(1'b0, 1'b1, 8);
    pulses(4, 4, 4, 1'b1);
    hold(1'b1, 1'b1, 2);
    A = 1'b0;
    do_reset(3);
    hold(1'b0, 1'b1, 10);
    chk("reset_low", 0, 8'd0);

    do_reset(2);
    repeat (400) begin
      lvl = 1'($urandom_range(0, 1));
      hold(lvl, $urandom_range(0, 3) != 0, $urandom_range(1, 8));
    end
    hold(1'b0, 1'b1, 12);
    chk_all("random");

    hold(1'b0, 1'b0, 10);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL final_pending pending=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
